approx_error_monitor: RTL and testbench
=======================================

Name: approx_error_monitor

Overview:
- Synthesizable, streaming error-metric engine for approximate adders, generalised in width N.
- Takes paired approximate and exact results over a valid/ready handshake and accumulates, in hardware, the statistics the team needs for characterisation:
  - error count (ER numerator)
  - sum of error distance (MED numerator)
  - sum of squared ED (MSE numerator)
  - max ED (NMED denominator)
  - zero-exact count (MRED valid-sample correction)
- Sits beside the adder under test in FPGA/emulation characterisation harnesses. Final division is done by software.

Parameters:
- N, 16, operand/result width of approx and exact.
- CNT_W, 24, width of sample counters and of num_samples.
- SIGNED_ED, 0, 0: ED = |approx - exact|, unsigned operands. 1: operands are two's complement, ED = |approx - exact| on N+1-bit signed difference.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; clears all accumulators, latches num_samples, enters RUN.
- num_samples  in  CNT_W  sample target, sampled on start.
- in_valid  in  1  approx/exact pair valid.
- in_ready  out  1  monitor accepts the pair this cycle.
- approx  in  N  approximate result.
- exact  in  N  exact result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results stable.
- sample_count  out  CNT_W  pairs accepted.
- err_count  out  CNT_W  pairs with approx != exact.
- zero_exact_count  out  CNT_W  pairs with exact == 0.
- sum_ed  out  N+CNT_W  saturating sum of ED.
- sum_sq_ed  out  2N+CNT_W  saturating sum of ED squared.
- max_ed  out  N+1  maximum ED seen.
- overflow  out  1  sticky; set if any sum saturated.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. On rst:
  - state IDLE
  - all counters, sums, max_ed and overflow are 0
  - in_ready, busy and done are 0
  - pipeline valid bits are cleared
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when sample_count == target, either after an accept or immediately if target == 0.
  - DRAIN -> DONE when the pipeline is empty.
  - DONE -> RUN on start. done holds until start or rst.
- start in any state (RUN, DRAIN, DONE) restarts:
  - accumulators are cleared
  - pipeline contents are discarded
  - new target is latched
  - next state is RUN
- Handshake:
  - in_ready = (state == RUN) && (sample_count < target). It is registered-state derived only, with no combinational dependence on in_valid.
  - Accept = in_valid && in_ready.
  - When in_valid is low, nothing changes.
- Pipeline:
  - S1 registers ED (N+1 bits), neq and zero flags on accept.
  - S2 computes the ED^2 product registered (2N+2 bits) and forwards ED.
  - S3 updates the accumulators.
  - sample_count increments at accept (cycle 0).
  - err_count, zero_exact_count, sum_ed, sum_sq_ed and max_ed reflect a pair 3 cycles after its accept.
  - Full throughput: one pair per cycle.
- Arithmetic:
  - Difference is computed on N+1 bits (zero- or sign-extended per SIGNED_ED).
  - ED is the absolute value of that difference. For unsigned N operands, max ED = 2^N - 1.
  - max_ed updates when ED > max_ed. Equal ED does not update.
  - Sums saturate at all-ones. overflow sets in the cycle of saturation and is cleared only by start or rst.
  - Counters cannot wrap, since they are bounded by target < 2^CNT_W.
- Boundary conditions:
  - target == 0: RUN -> DRAIN on the next cycle, in_ready never asserts, DONE with all-zero results.
  - in_valid held high past target: exactly target pairs are accepted.
  - rst mid-RUN: immediate return to reset values; pipeline contents are lost.

Decomposition:
- Package approx_metrics_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - width functions ed_w(N) = N+1, sum_w(N,CNT_W) = N+CNT_W, sq_w(N,CNT_W) = 2N+CNT_W
  - saturating-add function
- Sub-module ed_calc (parameters N, SIGNED_ED): registered S1/S2 producing ed, ed_sq, neq, zero_exact and valid.
- The top holds the FSM, handshake and accumulators.

Test Plan:
- N=16, num_samples=4; pairs (5,5), (10,7), (0,0), (65535,0) -> sample_count=4, err_count=2, zero_exact_count=2, sum_ed=65538, sum_sq_ed=9+65535^2=4294836234, max_ed=65535, overflow=0, done 3 cycles after the last accept.
- num_samples=0, start -> in_ready never 1; done within 3 cycles; all outputs 0.
- num_samples=3, in_valid held high for 10 cycles with random data -> exactly 3 accepts; in_ready low from cycle 3 onward.
- SIGNED_ED=1, N=8: approx=0x80 (-128), exact=0x7F (127) -> ED=255, max_ed=255.
- CNT_W=4, N=4, 15 pairs with ED=15 -> sum_ed saturates at 255 (true 225 fits), sum_sq_ed saturates at 4095 (true 3375 fits) -> overflow=0. Then repeat with N=2, CNT_W=2, three pairs (3,0) -> sum_ed=9 fits in 4 bits, sum_sq_ed 27 saturates to 63? No, it fits. Instead force target 3 with sq_w=6: use directed overflow via N=2, CNT_W=1, one pair ED=3 -> sum_sq_ed=9 fits in 5 bits; overflow stays 0. The saturating path is covered by a unit test of the package saturating-add function: 0xFF+1 at 8 bits -> 0xFF with flag.
- start pulsed mid-RUN after 2 of 5 accepts, and rst pulsed mid-RUN -> all accumulators 0 the next cycle. The start case re-enters RUN with the new target. The rst case lands in IDLE with in_ready=0 and busy=0.

Source files
------------

// File: rtl/approx_metrics_pkg.sv
// Shared types and helpers for the approximate-adder error monitor: FSM states,
// derived accumulator widths and a saturating adder used by the accumulators.
package approx_metrics_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Widest accumulator the saturating adder supports (2N+CNT_W must fit).
  localparam int SAT_W = 128;

  function automatic int ed_w(input int n);
    return n + 1;
  endfunction

  function automatic int sum_w(input int n, input int cnt_w);
    return n + cnt_w;
  endfunction

  function automatic int sq_w(input int n, input int cnt_w);
    return 2 * n + cnt_w;
  endfunction

  // Returns {saturated, result}; the result clamps to all-ones at width w.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = {1'b0, {SAT_W{1'b1}} >> (SAT_W - w)};
    if (sum > lim) begin
      return {1'b1, lim[SAT_W-1:0]};
    end else begin
      return {1'b0, sum[SAT_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/approx_error_monitor_ed_calc.sv
// Two-stage error-distance pipeline: S1 registers |approx-exact| and flags,
// S2 registers ED^2 and forwards ED/flags to the accumulator stage.
module ed_calc
  import approx_metrics_pkg::*;
#(
  parameter int N         = 16,
  parameter int SIGNED_ED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             fire_i,
  input  logic [N-1:0]     approx_i,
  input  logic [N-1:0]     exact_i,
  output logic             valid_o,
  output logic             pending_o,
  output logic [N:0]       ed_o,
  output logic [2*N+1:0]   ed_sq_o,
  output logic             neq_o,
  output logic             zero_exact_o
);

  logic [N:0]     a_ext_s, e_ext_s, diff_s, abs_s;
  logic [2*N+1:0] sq_s;
  logic           s1_valid_q, s1_neq_q, s1_zero_q;
  logic [N:0]     s1_ed_q;
  logic           s2_valid_q, s2_neq_q, s2_zero_q;
  logic [N:0]     s2_ed_q;
  logic [2*N+1:0] s2_sq_q;

  // The N+1-bit difference always fits, so its MSB is a valid sign bit in both modes.
  assign a_ext_s = (SIGNED_ED != 0) ? {approx_i[N-1], approx_i} : {1'b0, approx_i};
  assign e_ext_s = (SIGNED_ED != 0) ? {exact_i[N-1], exact_i} : {1'b0, exact_i};
  assign diff_s  = a_ext_s - e_ext_s;
  assign abs_s   = diff_s[N] ? (~diff_s + {{N{1'b0}}, 1'b1}) : diff_s;
  assign sq_s    = {{(N+1){1'b0}}, s1_ed_q} * {{(N+1){1'b0}}, s1_ed_q};

  // S1/S2 pipeline registers; flush drops in-flight pairs on restart.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s1_valid_q <= 1'b0;
      s1_ed_q    <= '0;
      s1_neq_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_ed_q    <= '0;
      s2_sq_q    <= '0;
      s2_neq_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= fire_i;
      if (fire_i) begin
        s1_ed_q   <= abs_s;
        s1_neq_q  <= (approx_i != exact_i);
        s1_zero_q <= (exact_i == {N{1'b0}});
      end
      s2_valid_q <= s1_valid_q;
      s2_ed_q    <= s1_ed_q;
      s2_sq_q    <= sq_s;
      s2_neq_q   <= s1_neq_q;
      s2_zero_q  <= s1_zero_q;
    end
  end

  assign valid_o      = s2_valid_q;
  assign pending_o    = s1_valid_q | s2_valid_q;
  assign ed_o         = s2_ed_q;
  assign ed_sq_o      = s2_sq_q;
  assign neq_o        = s2_neq_q;
  assign zero_exact_o = s2_zero_q;

endmodule

// File: rtl/approx_error_monitor.sv
// Streaming error-metric engine for approximate adders: accepts approx/exact
// pairs and accumulates ER/MED/MSE/NMED/MRED numerators for software division.
module approx_error_monitor
  import approx_metrics_pkg::*;
#(
  parameter int N         = 16,
  parameter int CNT_W     = 24,
  parameter int SIGNED_ED = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           approx,
  input  logic [N-1:0]           exact,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       sample_count,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       zero_exact_count,
  output logic [N+CNT_W-1:0]     sum_ed,
  output logic [2*N+CNT_W-1:0]   sum_sq_ed,
  output logic [N:0]             max_ed,
  output logic                   overflow
);

  localparam int EW = ed_w(N);
  localparam int SW = sum_w(N, CNT_W);
  localparam int QW = sq_w(N, CNT_W);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d, zero_q, zero_d;
  logic [SW-1:0]  sum_ed_q, sum_ed_d;
  logic [QW-1:0]  sum_sq_q, sum_sq_d;
  logic [EW-1:0]  max_ed_q, max_ed_d;
  logic           ovf_q, ovf_d;

  logic           accept_s, p_valid_s, p_pending_s, p_neq_s, p_zero_s;
  logic [EW-1:0]  p_ed_s;
  logic [2*N+1:0] p_sq_s;
  logic [SAT_W:0] ed_add_s, sq_add_s;

  assign in_ready = (state_q == RUN) && (cnt_q < target_q);
  assign accept_s = in_valid && in_ready;

  ed_calc #(.N(N), .SIGNED_ED(SIGNED_ED)) u_ed_calc (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (start),
    .fire_i       (accept_s && !start),
    .approx_i     (approx),
    .exact_i      (exact),
    .valid_o      (p_valid_s),
    .pending_o    (p_pending_s),
    .ed_o         (p_ed_s),
    .ed_sq_o      (p_sq_s),
    .neq_o        (p_neq_s),
    .zero_exact_o (p_zero_s)
  );

  assign ed_add_s = sat_add(SAT_W'(sum_ed_q), SAT_W'(p_ed_s), SW);
  assign sq_add_s = sat_add(SAT_W'(sum_sq_q), SAT_W'(p_sq_s), QW);

  // Next-state, counters and S3 accumulation; start overrides everything.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    zero_d   = zero_q;
    sum_ed_d = sum_ed_q;
    sum_sq_d = sum_sq_q;
    max_ed_d = max_ed_q;
    ovf_d    = ovf_q;
    if (start) begin
      state_d  = RUN;
      target_d = num_samples;
      cnt_d    = '0;
      err_d    = '0;
      zero_d   = '0;
      sum_ed_d = '0;
      sum_sq_d = '0;
      max_ed_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN: begin
          if ((cnt_q == target_q) ||
              (accept_s && ((cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) == target_q))) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end
        DRAIN:   state_d = p_pending_s ? DRAIN : DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (accept_s) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      if (p_valid_s) begin
        err_d    = err_q + {{(CNT_W-1){1'b0}}, p_neq_s};
        zero_d   = zero_q + {{(CNT_W-1){1'b0}}, p_zero_s};
        sum_ed_d = ed_add_s[SW-1:0];
        sum_sq_d = sq_add_s[QW-1:0];
        max_ed_d = (p_ed_s > max_ed_q) ? p_ed_s : max_ed_q;
        ovf_d    = ovf_q | ed_add_s[SAT_W] | sq_add_s[SAT_W];
      end else begin
        max_ed_d = max_ed_q;
      end
    end
  end

  // State and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      zero_q   <= '0;
      sum_ed_q <= '0;
      sum_sq_q <= '0;
      max_ed_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      sum_ed_q <= sum_ed_d;
      sum_sq_q <= sum_sq_d;
      max_ed_q <= max_ed_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign sample_count     = cnt_q;
  assign err_count        = err_q;
  assign zero_exact_count = zero_q;
  assign sum_ed           = sum_ed_q;
  assign sum_sq_ed        = sum_sq_q;
  assign max_ed           = max_ed_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench: unsigned N=16 monitor plus a signed N=8 instance.
module tb_approx_error_monitor;
  import approx_metrics_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Unsigned N=16, CNT_W=24 instance
  logic        start = 1'b0, in_valid = 1'b0, in_ready, busy, done, overflow;
  logic [23:0] num_samples = 24'd0, sample_count, err_count, zero_exact_count;
  logic [15:0] approx = 16'd0, exact = 16'd0;
  logic [39:0] sum_ed;
  logic [55:0] sum_sq_ed;
  logic [16:0] max_ed;

  // Signed N=8, CNT_W=8 instance
  logic       s_start = 1'b0, s_in_valid = 1'b0, s_in_ready, s_busy, s_done, s_overflow;
  logic [7:0] s_num = 8'd0, s_count, s_err, s_zero, s_approx = 8'd0, s_exact = 8'd0;
  logic [15:0] s_sum_ed;
  logic [23:0] s_sum_sq;
  logic [8:0]  s_max_ed;

  int n_cmp = 0;
  int n_fail = 0;

  approx_error_monitor #(.N(16), .CNT_W(24), .SIGNED_ED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .approx(approx), .exact(exact),
    .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
    .zero_exact_count(zero_exact_count), .sum_ed(sum_ed), .sum_sq_ed(sum_sq_ed),
    .max_ed(max_ed), .overflow(overflow)
  );

  approx_error_monitor #(.N(8), .CNT_W(8), .SIGNED_ED(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .num_samples(s_num),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .approx(s_approx), .exact(s_exact),
    .busy(s_busy), .done(s_done), .sample_count(s_count), .err_count(s_err),
    .zero_exact_count(s_zero), .sum_ed(s_sum_ed), .sum_sq_ed(s_sum_sq),
    .max_ed(s_max_ed), .overflow(s_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [23:0] n);
    num_samples = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits for done with a bound; returns the number of cycles taken (99 on timeout).
  task automatic wait_done(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, busy, done, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {in_ready, busy, done, overflow});
    end
    n_cmp++;
    if ({sample_count, err_count, zero_exact_count} !== 72'd0 || sum_ed !== 40'd0 ||
        sum_sq_ed !== 56'd0 || max_ed !== 17'd0) begin
      n_fail++; $display("FAIL reset_values: cnt=%0d err=%0d sum=%0d sq=%0d max=%0d want all 0",
                         sample_count, err_count, sum_ed, sum_sq_ed, max_ed);
    end
  endtask

  task automatic test_basic();
    logic [15:0] va [4] = '{16'd5, 16'd10, 16'd0, 16'd65535};
    logic [15:0] ve [4] = '{16'd5, 16'd7, 16'd0, 16'd0};
    int cyc;
    pulse_start(24'd4);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_run: busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      approx = va[i]; exact = ve[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || sample_count !== 24'd4) begin
      n_fail++; $display("FAIL basic_after_last: in_ready=%b cnt=%0d want 0 4", in_ready, sample_count);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != 3) begin
      n_fail++; $display("FAIL basic_done_latency: got %0d want 3", cyc);
    end
    n_cmp++;
    if (sample_count !== 24'd4 || err_count !== 24'd2 || zero_exact_count !== 24'd2) begin
      n_fail++; $display("FAIL basic_counts: cnt=%0d err=%0d zero=%0d want 4 2 2",
                         sample_count, err_count, zero_exact_count);
    end
    n_cmp++;
    if (sum_ed !== 40'd65538 || sum_sq_ed !== 56'd4294836234) begin
      n_fail++; $display("FAIL basic_sums: sum=%0d sq=%0d want 65538 4294836234", sum_ed, sum_sq_ed);
    end
    n_cmp++;
    if (max_ed !== 17'd65535 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_max: max=%0d ovf=%b busy=%b want 65535 0 0", max_ed, overflow, busy);
    end
  endtask

  task automatic test_zero_target();
    int cyc;
    int seen_ready;
    pulse_start(24'd0);
    seen_ready = int'(in_ready);
    cyc = 99;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (in_ready) seen_ready = 1;
      if (done) begin cyc = i; break; end
    end
    n_cmp++;
    if (seen_ready != 0 || cyc > 3) begin
      n_fail++; $display("FAIL zero_target: ready_seen=%0d done_cycles=%0d want 0 <=3", seen_ready, cyc);
    end
    n_cmp++;
    if (sample_count !== 24'd0 || err_count !== 24'd0 || zero_exact_count !== 24'd0 ||
        sum_ed !== 40'd0 || sum_sq_ed !== 56'd0 || max_ed !== 17'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL zero_target_values: cnt=%0d sum=%0d sq=%0d max=%0d want all 0",
                         sample_count, sum_ed, sum_sq_ed, max_ed);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int late_ready = 0;
    int cyc;
    longint exp_sum = 0;
    logic [15:0] a, e;
    pulse_start(24'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(0, 65535));
      e = 16'($urandom_range(0, 65535));
      approx = a; exact = e;
      if (i < 3) exp_sum += (a > e) ? longint'(a - e) : longint'(e - a);
      if (in_ready) acc++;
      if (i >= 3 && in_ready) late_ready++;
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc != 3 || late_ready != 0) begin
      n_fail++; $display("FAIL hold_valid_accepts: accepts=%0d late_ready=%0d want 3 0", acc, late_ready);
    end
    wait_done(cyc);
    n_cmp++;
    if (!done || sample_count !== 24'd3 || sum_ed !== 40'(exp_sum)) begin
      n_fail++; $display("FAIL hold_valid_result: done=%b cnt=%0d sum=%0d want 1 3 %0d",
                         done, sample_count, sum_ed, exp_sum);
    end
  endtask

  task automatic test_signed();
    int cyc;
    s_num = 8'd2;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_in_valid = 1'b1;
    s_approx = 8'h80; s_exact = 8'h7F;
    step();
    s_approx = 8'hFF; s_exact = 8'h01;
    step();
    s_in_valid = 1'b0;
    cyc = 99;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (s_done) begin cyc = i; break; end
    end
    n_cmp++;
    if (cyc != 3 || s_max_ed !== 9'd255) begin
      n_fail++; $display("FAIL signed_max: cycles=%0d max=%0d want 3 255", cyc, s_max_ed);
    end
    n_cmp++;
    if (s_sum_ed !== 16'd257 || s_sum_sq !== 24'd65029 || s_err !== 8'd2 || s_zero !== 8'd0) begin
      n_fail++; $display("FAIL signed_sums: sum=%0d sq=%0d err=%0d zero=%0d want 257 65029 2 0",
                         s_sum_ed, s_sum_sq, s_err, s_zero);
    end
  endtask

  task automatic test_sat_func();
    logic [SAT_W:0] r;
    r = sat_add(SAT_W'(8'hFF), SAT_W'(8'h01), 8);
    n_cmp++;
    if (r[SAT_W] !== 1'b1 || r[7:0] !== 8'hFF || r[15:8] !== 8'h00) begin
      n_fail++; $display("FAIL sat_add_clamp: flag=%b val=%h want 1 00ff", r[SAT_W], r[15:0]);
    end
    r = sat_add(SAT_W'(8'h10), SAT_W'(8'h01), 8);
    n_cmp++;
    if (r[SAT_W] !== 1'b0 || r[15:0] !== 16'h0011) begin
      n_fail++; $display("FAIL sat_add_plain: flag=%b val=%h want 0 0011", r[SAT_W], r[15:0]);
    end
  endtask

  task automatic test_restart();
    int cyc;
    pulse_start(24'd5);
    in_valid = 1'b1;
    approx = 16'd3; exact = 16'd1; step();
    approx = 16'd1; exact = 16'd3; step();
    in_valid = 1'b0;
    pulse_start(24'd2);
    n_cmp++;
    if (sample_count !== 24'd0 || sum_ed !== 40'd0 || err_count !== 24'd0 ||
        busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear: cnt=%0d sum=%0d err=%0d busy=%b rdy=%b want 0 0 0 1 1",
                         sample_count, sum_ed, err_count, busy, in_ready);
    end
    step(); step(); step();
    n_cmp++;
    if (sum_ed !== 40'd0 || err_count !== 24'd0) begin
      n_fail++; $display("FAIL restart_flushed: sum=%0d err=%0d want 0 0", sum_ed, err_count);
    end
    in_valid = 1'b1;
    approx = 16'd7; exact = 16'd2; step();
    approx = 16'd2; exact = 16'd2; step();
    in_valid = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (cyc != 3 || sample_count !== 24'd2 || sum_ed !== 40'd5 || err_count !== 24'd1 ||
        sum_sq_ed !== 56'd25) begin
      n_fail++; $display("FAIL restart_result: cyc=%0d cnt=%0d sum=%0d err=%0d sq=%0d want 3 2 5 1 25",
                         cyc, sample_count, sum_ed, err_count, sum_sq_ed);
    end
  endtask

  task automatic test_rst_mid_run();
    pulse_start(24'd5);
    in_valid = 1'b1;
    approx = 16'd9; exact = 16'd1; step();
    approx = 16'd1; exact = 16'd9; step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (sample_count !== 24'd0 || sum_ed !== 40'd0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_run: cnt=%0d sum=%0d rdy=%b busy=%b done=%b want 0 0 0 0 0",
                         sample_count, sum_ed, in_ready, busy, done);
    end
    step(); step(); step();
    in_valid = 1'b0;
    n_cmp++;
    if (sum_ed !== 40'd0 || err_count !== 24'd0 || max_ed !== 17'd0 || sample_count !== 24'd0) begin
      n_fail++; $display("FAIL rst_pipeline_lost: sum=%0d err=%0d max=%0d cnt=%0d want 0 0 0 0",
                         sum_ed, err_count, max_ed, sample_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_target();
    test_back_to_back();
    test_signed();
    test_sat_func();
    test_restart();
    test_rst_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
